// File: rtl/fpmul_link_pkg.sv
// rtl/fpmul_link_pkg.sv - shared states, pin field positions and error codes for the fpmul pin link
package fpmul_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } link_state_e;

    localparam int PO_W        = 23;
    localparam int PO_STROBE   = 22;
    localparam int PO_SEL_LSB  = 20;
    localparam int PO_HALF_LSB = 0;

    localparam int PI_W        = 12;
    localparam int PI_RVALID   = 11;
    localparam int PI_IDX_LSB  = 8;
    localparam int PI_BYTE_LSB = 0;

    localparam int NUM_BEATS = 4;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_SEQ     = 2'd2;

    function automatic logic [PO_W-1:0] pin_word(input logic [1:0] sel, input logic [15:0] half);
        logic [PO_W-1:0] w;
        w                       = '0;
        w[PO_STROBE]            = 1'b1;
        w[PO_SEL_LSB +: 2]      = sel;
        w[PO_HALF_LSB +: 16]    = half;
        return w;
    endfunction

endpackage

// File: rtl/fpmul_link_rx.sv
// rtl/fpmul_link_rx.sv - pin_in capture, beat order check, byte assembly and idle timeout
module fpmul_link_rx
    import fpmul_link_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            active_i,
    input  logic [PI_W-1:0] pin_in_i,
    output logic            done_o,
    output logic [31:0]     data_o,
    output logic [1:0]      err_o
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    logic [PI_W-1:0] pin_q;
    logic [1:0]      exp_q, exp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic [1:0]      err_q, err_d;

    logic       beat;
    logic [2:0] beat_idx;
    logic [7:0] beat_byte;

    assign beat      = pin_q[PI_RVALID];
    assign beat_idx  = pin_q[PI_IDX_LSB +: 3];
    assign beat_byte = pin_q[PI_BYTE_LSB +: 8];

    always_comb begin
        exp_d  = exp_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        err_d  = err_q;
        done_o = 1'b0;
        if (start_i) begin
            exp_d  = '0;
            cnt_d  = '0;
            data_d = '0;
            err_d  = ERR_OK;
        end else if (active_i) begin
            // A beat in the same cycle the counter expires still counts.
            if (beat) begin
                cnt_d = '0;
                if (beat_idx == {1'b0, exp_q}) begin
                    data_d[{exp_q, 3'b000} +: 8] = beat_byte;
                    exp_d  = exp_q + 2'd1;
                    done_o = (exp_q == 2'(NUM_BEATS - 1));
                end else begin
                    err_d  = ERR_SEQ;
                    done_o = 1'b1;
                end
            end else if (cnt_q == CNT_MAX) begin
                err_d  = ERR_TIMEOUT;
                done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pin_q  <= '0;
            exp_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            err_q  <= ERR_OK;
        end else begin
            pin_q  <= pin_in_i;
            exp_q  <= exp_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign data_o = data_q;
    assign err_o  = err_q;

endmodule

// File: rtl/fpmul_pin_driver.sv
// rtl/fpmul_pin_driver.sv - host link master serializing operands to the fpmul pins and collecting the product
module fpmul_pin_driver
    import fpmul_link_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [1:0]  res_err,
    output logic [22:0] pin_out,
    input  logic [11:0] pin_in,
    output logic        busy
);

    link_state_e     state_q, state_d;
    logic [1:0]      beat_q, beat_d;
    logic [63:0]     ops_q, ops_d;
    logic [PO_W-1:0] pin_out_q, pin_out_d;
    logic            rx_start;
    logic            rx_done;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        ops_d     = ops_q;
        pin_out_d = '0;
        rx_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    ops_d     = {op_b, op_a};
                    beat_d    = 2'd0;
                    pin_out_d = pin_word(2'd0, op_a[15:0]);
                    rx_start  = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_q == 2'(NUM_BEATS - 1)) begin
                    state_d = ST_WAIT;
                end else begin
                    // ops_q is {B, A}, so half-word index equals the beat number.
                    beat_d    = beat_q + 2'd1;
                    pin_out_d = pin_word(beat_d, ops_q[{beat_d, 4'b0000} +: 16]);
                end
            end
            ST_WAIT: begin
                if (rx_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            beat_q    <= 2'd0;
            ops_q     <= '0;
            pin_out_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            ops_q     <= ops_d;
            pin_out_q <= pin_out_d;
        end
    end

    fpmul_link_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .start_i  (rx_start),
        .active_i (state_q == ST_WAIT),
        .pin_in_i (pin_in),
        .done_o   (rx_done),
        .data_o   (res_data),
        .err_o    (res_err)
    );

    assign op_ready  = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign pin_out   = pin_out_q;

endmodule

// File: tb/tb_fpmul_pin_driver.sv
// tb/tb_fpmul_pin_driver.sv - randomized scoreboard bench for fpmul_pin_driver
`timescale 1ns/1ps
module tb_fpmul_pin_driver;

    localparam int TMO = 8;

    logic        wb_clk_i  = 1'b0;
    logic        wb_rst_i  = 1'b1;
    logic        op_valid  = 1'b0;
    logic        res_ready = 1'b0;
    logic [31:0] op_a      = '0;
    logic [31:0] op_b      = '0;
    logic [11:0] pin_in    = '0;
    logic        op_ready, res_valid, busy;
    logic [31:0] res_data;
    logic [1:0]  res_err;
    logic [22:0] pin_out;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  err;
    } res_t;

    res_t exp_q[$];

    always #5 wb_clk_i = ~wb_clk_i;

    fpmul_pin_driver #(.TIMEOUT(TMO)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .pin_out   (pin_out),
        .pin_in    (pin_in),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result from the beat list: in-order bytes are kept, first out-of-order index
    // is a sequence error, running out of beats before index 3 is a timeout.
    function automatic res_t model(input logic [3:0][2:0] idx, input logic [3:0][7:0] by, input int nb);
        res_t r;
        r.data = '0;
        r.err  = 2'd1;
        for (int k = 0; k < nb; k++) begin
            if (idx[k] != 3'(k)) begin
                r.err = 2'd2;
                return r;
            end
            r.data[8*k +: 8] = by[k];
            if (k == 3) begin
                r.err = 2'd0;
                return r;
            end
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (res_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got data=0x%0h err=%0d, wanted no result", res_data, res_err);
                end else begin
                    chk("res_data", res_data, exp_q[0].data);
                    chk("res_err", 32'(res_err), 32'(exp_q[0].err));
                    if (res_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit stray);
        logic [63:0] ab;
        int          n;
        ab = {b, a};
        n  = 0;
        while (op_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("op_ready_before_send", 32'(op_ready), 32'd1);
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        for (int k = 0; k < 4; k++) begin
            chk("pin_out_beat", 32'(pin_out), 32'h400000 | (32'(k) << 20) | 32'(ab[16*k +: 16]));
            pin_in = (stray && k == 1) ? 12'h800 : 12'h000;
            tick();
        end
        pin_in = '0;
        chk("pin_out_after_send", 32'(pin_out), 32'd0);
        chk("busy_in_wait", 32'(busy), 32'd1);
    endtask

    task automatic beat(input logic [2:0] idx, input logic [7:0] by, input int gap);
        pin_in = {1'b1, idx, by};
        tick();
        pin_in = '0;
        repeat (gap) tick();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("res_valid_arrives", 32'(res_valid), 32'd1);
    endtask

    task automatic finish_res(input int low);
        chk("op_ready_in_done", 32'(op_ready), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        repeat (low) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("op_ready_after_hs", 32'(op_ready), 32'd1);
        chk("res_valid_after_hs", 32'(res_valid), 32'd0);
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [3:0][2:0] idx,
                       input logic [3:0][7:0] by, input int nb, input int gap, input int low,
                       input bit stray, output int lat);
        int n;
        exp_q.push_back(model(idx, by, nb));
        send(a, b, stray);
        for (int k = 0; k < nb; k++) beat(idx[k], by[k], (k == nb - 1) ? 0 : gap);
        wait_valid(n);
        lat = (nb > 0) ? n + 1 : n;
        finish_res(low);
    endtask

    task automatic rand_txn(input bit allow_err);
        logic [3:0][2:0] idx;
        logic [3:0][7:0] by;
        int              nb;
        int              lat;
        idx = '0;
        by  = '0;
        nb  = 0;
        for (int k = 0; k < 4; k++) begin
            by[k]  = 8'($urandom);
            idx[k] = 3'(k);
            if (allow_err && $urandom_range(0, 7) == 0) idx[k] = 3'(k) ^ 3'($urandom_range(1, 7));
            nb = k + 1;
            if (idx[k] != 3'(k)) break;
        end
        txn($urandom, $urandom, idx, by, nb, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (2) tick();
        chk("rst_pin_out", 32'(pin_out), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        wb_rst_i = 1'b0;
        tick();

        txn(32'h3FC00000, 32'h40000000, {3'd3, 3'd2, 3'd1, 3'd0}, {8'h40, 8'h40, 8'h00, 8'h00},
            4, 0, 0, 1'b0, lat);
        chk("result_latency", 32'(lat), 32'd2);

        txn(32'h3FC00000, 32'h40000000, {3'd3, 3'd2, 3'd1, 3'd0}, {8'h40, 8'h40, 8'h00, 8'h00},
            4, 3, 5, 1'b0, lat);

        txn($urandom, $urandom, {3'd3, 3'd2, 3'd1, 3'd0}, {8'h00, 8'h00, 8'h34, 8'h12},
            2, 0, 1, 1'b0, lat);
        chk("timeout_latency", 32'(lat), 32'(TMO + 3));

        txn($urandom, $urandom, '0, '0, 0, 0, 0, 1'b0, lat);
        chk("timeout_no_beat_latency", 32'(lat), 32'(TMO + 1));

        txn($urandom, $urandom, {3'd3, 3'd2, 3'd2, 3'd0}, {8'h00, 8'h00, 8'h00, 8'h00},
            2, 0, 0, 1'b0, lat);
        chk("seq_err_latency", 32'(lat), 32'd2);

        pin_in = 12'h800;
        tick();
        pin_in = '0;
        repeat (3) tick();
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_op_ready", 32'(op_ready), 32'd1);
        txn(32'h12345678, 32'h9ABCDEF0, {3'd3, 3'd2, 3'd1, 3'd0}, {8'hA4, 8'h93, 8'h82, 8'h71},
            4, 1, 0, 1'b1, lat);

        op_a     = 32'hCAFEF00D;
        op_b     = 32'h0BADBEEF;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        chk("pin_out_beat2_before_rst", 32'(pin_out), 32'h60BEEF);
        wb_rst_i = 1'b1;
        #1;
        chk("rst_send_pin_out", 32'(pin_out), 32'd0);
        chk("rst_send_busy", 32'(busy), 32'd0);
        chk("rst_send_op_ready", 32'(op_ready), 32'd1);
        tick();
        wb_rst_i = 1'b0;
        tick();
        rand_txn(1'b0);

        send(32'h11111111, 32'h22222222, 1'b0);
        beat(3'd0, 8'h5A, 2);
        wb_rst_i = 1'b1;
        #1;
        chk("rst_wait_pin_out", 32'(pin_out), 32'd0);
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_op_ready", 32'(op_ready), 32'd1);
        chk("rst_wait_res_data", res_data, 32'd0);
        tick();
        wb_rst_i = 1'b0;
        tick();
        rand_txn(1'b0);

        for (int i = 0; i < 40; i++) rand_txn(1'b1);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
